// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline front end.
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- shown to decode whenever no real instruction is available
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered fetch result: the instruction word and the PC it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory handshake and decode-side outputs of the fetch front end.
interface fetch_queue_if;
    import riscv_pipe_pkg::*;

    // Instruction memory request / response
    logic            ImemReqValid;
    logic [XLEN-1:0] ImemReqAddr;
    logic            ImemReqReady;
    logic            ImemRespValid;
    logic [XLEN-1:0] ImemRespData;

    // Execute-stage redirect and decode back-pressure
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallF;

    // Instruction presented to the IF/ID register
    logic            ValidF;
    logic [XLEN-1:0] InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;

    // Fetch front end side
    modport master (
        output ImemReqValid, ImemReqAddr,
        input  ImemReqReady, ImemRespValid, ImemRespData,
        input  PCSrcE, PCTargetE, StallF,
        output ValidF, InstrF, PCF, PCPlus4F
    );

    // Memory / pipeline environment side
    modport slave (
        input  ImemReqValid, ImemReqAddr,
        output ImemReqReady, ImemRespValid, ImemRespData,
        output PCSrcE, PCTargetE, StallF,
        input  ValidF, InstrF, PCF, PCPlus4F
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is visible combinationally.
module fetch_fifo
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_pop;
    logic            do_push;

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine alongside it
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping; a flush overrides any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage holds data only, so it is written but never reset
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps up to DEPTH requests
// outstanding to a variable-latency memory, buffers returned words with their
// PC and hands one instruction per cycle to decode, honouring stalls and
// execute-stage redirects.
module fetch_queue
    import riscv_pipe_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;

    logic            req_fire;
    logic            resp_take;
    logic            resp_push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Issue only while buffered plus outstanding work leaves room for one more
    // response, so a response can never find the FIFO full without a pop.
    assign bus.ImemReqValid = !rst && !bus.PCSrcE &&
                              (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH));
    assign bus.ImemReqAddr  = fetch_pc;
    assign req_fire         = bus.ImemReqValid && bus.ImemReqReady;

    // A response with nothing outstanding is spurious and leaves no trace.
    // Responses owed to requests issued before a redirect are discarded.
    assign resp_take  = bus.ImemRespValid && (inflight != '0);
    assign resp_push  = resp_take && (drop == '0) && !bus.PCSrcE;
    assign push_entry = '{pc: resp_pc, instr: bus.ImemRespData};

    assign pop = bus.ValidF && !bus.StallF;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_push),
        .pop   (pop),
        .clear (bus.PCSrcE),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    // Fetch/response PCs, outstanding-request count and stale-response count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(resp_take);
            if (bus.PCSrcE) begin
                // Everything still outstanding after this cycle belongs to the old path
                fetch_pc <= bus.PCTargetE;
                resp_pc  <= bus.PCTargetE;
                drop     <= inflight - CW'(resp_take);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (resp_take && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Decode sees the FIFO head, or a NOP at PC 0 when nothing is buffered
    assign bus.ValidF   = (count != '0);
    assign bus.InstrF   = bus.ValidF ? head.instr : NOP_INSTR;
    assign bus.PCF      = bus.ValidF ? head.pc : '0;
    assign bus.PCPlus4F = bus.PCF + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: an in-order memory model with configurable latency
// drives the DUT, and a queue-based reference model predicts every cycle's
// outputs from the fetch rules.
module tb_fetch_queue;
    import riscv_pipe_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    fetch_queue_if bus ();
    fetch_queue_if bus2 ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Memory model: accepted requests waiting for their response cycle
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    // Reference model: outstanding requests and buffered instructions
    typedef struct { logic [31:0] addr; bit stale; } oreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mem_q [$];
    oreq_t       out_q [$];
    ent_t        fq [$];
    logic [31:0] fetch_pc;
    int          cyc;
    int          last_due;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic bound(input string tag, input bit ok);
        assert (ok) else begin
            miscompares++;
            $error("FAIL %s: cycle budget expired before the condition was reached", tag);
        end
    endtask

    // One clock cycle, entered and left at the negedge
    task automatic step(input bit pcsrc, input logic [31:0] tgt, input bit stall,
                        input bit rdy, input bit spur, input int lat);
        bit          rv;
        logic [31:0] rd;
        bit          ev;
        bit          reqv;
        bit          fire;
        bit          pop;
        bit          got;
        oreq_t       o;
        int          due;

        rv = 1'b0;
        rd = $urandom;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            rv = 1'b1;
            rd = word(mem_q[0].addr);
            mem_q.delete(0);
        end else if (spur && mem_q.size() == 0 && out_q.size() == 0) begin
            rv = 1'b1;
        end
        bus.PCSrcE        = pcsrc;
        bus.PCTargetE     = tgt;
        bus.StallF        = stall;
        bus.ImemReqReady  = rdy;
        bus.ImemRespValid = rv;
        bus.ImemRespData  = rd;
        #1;

        ev   = (fq.size() != 0);
        reqv = !pcsrc && (fq.size() + out_q.size() < DEPTH);
        chk("ValidF", 32'(bus.ValidF), 32'(ev));
        chk("ImemReqValid", 32'(bus.ImemReqValid), 32'(reqv));
        if (reqv) chk("ImemReqAddr", bus.ImemReqAddr, fetch_pc);
        if (ev) begin
            chk("PCF", bus.PCF, fq[0].pc);
            chk("InstrF", bus.InstrF, fq[0].instr);
            chk("PCPlus4F", bus.PCPlus4F, fq[0].pc + 32'd4);
        end else begin
            chk("InstrF_nop", bus.InstrF, NOP_INSTR);
        end

        // Memory accepts whatever the DUT actually offers
        if (bus.ImemReqValid && rdy) begin
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            mem_q.push_back('{bus.ImemReqAddr, due});
        end

        // Reference model state update
        fire = reqv && rdy;
        pop  = ev && !stall;
        got  = 1'b0;
        o    = '{32'h0, 1'b0};
        if (rv && out_q.size() != 0) begin
            o = out_q[0];
            out_q.delete(0);
            got = !o.stale;
        end
        if (pcsrc) begin
            fq.delete();
            for (int i = 0; i < out_q.size(); i++) out_q[i].stale = 1'b1;
            fetch_pc = tgt;
        end else begin
            if (pop) fq.delete(0);
            if (got) fq.push_back('{o.addr, word(o.addr)});
            if (fire) begin
                out_q.push_back('{fetch_pc, 1'b0});
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (fq.size() != 0 || out_q.size() != 0); i++)
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        bound("drain", fq.size() == 0 && out_q.size() == 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        last_due    = 0;
        fetch_pc    = RESET_PC;
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.PCSrcE  = 1'b0; bus.PCTargetE  = '0; bus.StallF  = 1'b0;
        bus.ImemReqReady  = 1'b0; bus.ImemRespValid  = 1'b0; bus.ImemRespData  = '0;
        bus2.PCSrcE = 1'b0; bus2.PCTargetE = '0; bus2.StallF = 1'b0;
        bus2.ImemReqReady = 1'b0; bus2.ImemRespValid = 1'b0; bus2.ImemRespData = '0;

        @(negedge clk);
        chk("reset_ValidF", 32'(bus.ValidF), 32'h0);
        chk("reset_InstrF", bus.InstrF, NOP_INSTR);
        chk("reset_PCF", bus.PCF, 32'h0);
        chk("reset_PCPlus4F", bus.PCPlus4F, 32'h4);
        chk("reset_ReqValid", 32'(bus.ImemReqValid), 32'h0);

        // Second instance: RESET_PC near the top, spurious response, PC wrap
        rst2 = 1'b0;
        bus2.ImemRespValid = 1'b1; bus2.ImemRespData = 32'hDEAD_BEEF;
        #1;
        chk("wrap_reqv0", 32'(bus2.ImemReqValid), 32'h1);
        chk("wrap_addr0", bus2.ImemReqAddr, 32'hFFFF_FFF8);
        @(negedge clk);
        bus2.ImemRespValid = 1'b0; bus2.ImemReqReady = 1'b1;
        #1;
        chk("spurious_no_push", 32'(bus2.ValidF), 32'h0);
        chk("wrap_addr1", bus2.ImemReqAddr, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap_addr2", bus2.ImemReqAddr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap_addr3", bus2.ImemReqAddr, 32'h0000_0000);
        @(negedge clk);
        bus2.ImemReqReady = 1'b0; bus2.ImemRespValid = 1'b1; bus2.ImemRespData = 32'h11;
        #1;
        chk("wrap_no_bypass", 32'(bus2.ValidF), 32'h0);
        chk("wrap_addr4", bus2.ImemReqAddr, 32'h0000_0004);
        @(negedge clk);
        bus2.ImemRespData = 32'h22;
        #1;
        chk("wrap_pcf0", bus2.PCF, 32'hFFFF_FFF8);
        chk("wrap_instr0", bus2.InstrF, 32'h11);
        chk("wrap_pc4_0", bus2.PCPlus4F, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.ImemRespData = 32'h33;
        #1;
        chk("wrap_pcf1", bus2.PCF, 32'hFFFF_FFFC);
        chk("wrap_instr1", bus2.InstrF, 32'h22);
        chk("wrap_pc4_1", bus2.PCPlus4F, 32'h0000_0000);
        @(negedge clk);
        bus2.ImemRespValid = 1'b0;
        #1;
        chk("wrap_pcf2", bus2.PCF, 32'h0000_0000);
        chk("wrap_instr2", bus2.InstrF, 32'h33);
        @(negedge clk); #1;
        chk("wrap_empty", 32'(bus2.ValidF), 32'h0);
        rst2 = 1'b1;

        // Main instance: release reset
        @(negedge clk);
        rst = 1'b0;

        // Always-ready 1-cycle memory
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);

        // Long stall then release
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        for (int i = 0; i < 8; i++)  step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);

        // Latency 3, redirect with two requests in flight
        drain();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3);
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 15 && !bus.ValidF; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3);
        bound("redirect_wait", bus.ValidF === 1'b1);
        chk("redirect_pcf", bus.PCF, 32'h100);
        chk("redirect_instr", bus.InstrF, 32'h40);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3);

        // Redirect with a full FIFO, a pop and a response in the same cycle
        drain();
        for (int i = 0; i < 20 && fq.size() != DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        bound("fill_full", fq.size() == DEPTH);
        step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1);
        chk("flush_valid", 32'(bus.ValidF), 32'h0);
        chk("flush_nop", bus.InstrF, NOP_INSTR);
        for (int i = 0; i < 20 && !(fq.size() == 3 && out_q.size() == 1); i++)
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        bound("fill_three", fq.size() == 3 && out_q.size() == 1);
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1);
        chk("flush2_valid", 32'(bus.ValidF), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 5), ($urandom & 32'hFFFF_FFFC),
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < 10), $urandom_range(1, 6));
        end

        // Asynchronous reset with three entries buffered and one in flight
        drain();
        for (int i = 0; i < 20 && fq.size() != 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1);
        bound("fill_reset", fq.size() == 3);
        #3 rst = 1'b1;
        #1;
        chk("async_ValidF", 32'(bus.ValidF), 32'h0);
        chk("async_InstrF", bus.InstrF, NOP_INSTR);
        chk("async_PCF", bus.PCF, 32'h0);
        chk("async_PCPlus4F", bus.PCPlus4F, 32'h4);
        chk("async_ReqValid", 32'(bus.ImemReqValid), 32'h0);
        fq.delete();
        out_q.delete();
        fetch_pc = RESET_PC;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)  step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, ($urandom_range(0, 99) < 30), 1'b1, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
